uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high (ports CLK, RST).
REQ-002 SHALL have ports, each as name  direction  width  meaning:
- CLK  in  1  oversampling clock.
- RST  in  1  synchronous active-high reset.
- RX_IN  in  1  serial line, idle high.
- PAR_EN  in  1  parity bit present in frame.
- prescale  in  6  oversampling ratio.
- strt_glitch  in  1  start-check result.
- par_err  in  1  parity-check result.
- stp_err  in  1  stop-check result.
- edge_cnt  out  5  edge position within current bit.
- bit_cnt  out  4  data bits completed.
- dat_samp_en  out  1  sampler enable.
- strt_chk_en  out  1  start-check enable.
- deser_en  out  1  deserializer enable.
- par_chk_en  out  1  parity-check enable.
- stp_chk_en  out  1  stop-check enable.
- data_valid  out  1  one-cycle good-frame pulse.
- framing_err  out  1  one-cycle bad-frame pulse.

Function
REQ-003 SHALL define effective prescale P: prescale 8, 16 and 32 are used as-is; any other value is treated as 8.
REQ-004 SHALL implement states IDLE, START, DATA, PARITY, STOP and ERR_CHK in a registered state variable.
REQ-005 SHALL increment edge_cnt every cycle in START, DATA, PARITY and STOP, wrapping from P-1 to 0; "bit end" is the cycle where edge_cnt == P-1.
REQ-006 SHALL hold edge_cnt at 0 in IDLE and ERR_CHK.
REQ-007 SHALL move IDLE -> START on the first clock edge that samples RX_IN == 0; otherwise it stays in IDLE.
REQ-008 SHALL, in START at bit end, go to IDLE if strt_glitch == 1, else go to DATA with bit_cnt = 0.
REQ-009 SHALL increment bit_cnt at each DATA bit end; when bit_cnt == 7 at bit end, it goes to PARITY if PAR_EN == 1, else to STOP.
REQ-010 SHALL clear bit_cnt to 0 on leaving STOP, in IDLE, and in START.
REQ-011 SHALL, in PARITY at bit end, capture par_err into an internal flag and go to STOP; the flag is cleared on entering START.
REQ-012 SHALL, in STOP at bit end, capture stp_err into an internal flag and go to ERR_CHK.
REQ-013 SHALL remain in ERR_CHK exactly one cycle, then go to START if RX_IN == 0 (back-to-back frame), else to IDLE.
REQ-014 SHALL decode enables from the state register only:
- dat_samp_en = 1 in START, DATA, PARITY and STOP.
- strt_chk_en = 1 in START.
- deser_en = 1 in DATA.
- par_chk_en = 1 in PARITY.
- stp_chk_en = 1 in STOP.
REQ-015 SHALL assert data_valid = 1 in ERR_CHK only when both captured error flags are 0.
REQ-016 SHALL assert framing_err = 1 in ERR_CHK when either captured flag is 1; data_valid and framing_err are never both 1.
REQ-017 SHALL sample PAR_EN and prescale only on the IDLE/ERR_CHK -> START transition; changes mid-frame have no effect until the next frame.
REQ-018 SHALL ignore the error inputs outside their respective capture cycles.

Reset
REQ-019 SHALL, when RST == 1 at a clock edge (including mid-frame), return to IDLE and clear edge_cnt, bit_cnt and both error flags, with all outputs 0 in the following cycle.
REQ-020 SHALL emit no data_valid or framing_err pulse for a frame aborted by reset.

Verification
REQ-021 SHALL cover: P=8, PAR_EN=0, clean frame with RX_IN low at cycle 0 -> START entered at cycle 1, data_valid = 1 exactly at cycle 81, bit_cnt reaches 8 before STOP.
REQ-022 SHALL cover: P=8, PAR_EN=1, clean frame -> PARITY lasts 8 cycles, data_valid at cycle 89, framing_err stays 0.
REQ-023 SHALL cover: strt_glitch = 1 at START bit end -> back to IDLE, no DATA state, deser_en never 1, no output pulse.
REQ-024 SHALL cover: stp_err = 1 at STOP bit end (P=16) -> framing_err = 1 for one cycle, data_valid stays 0.
REQ-025 SHALL cover: RX_IN low during ERR_CHK -> next cycle is START with edge_cnt = 0; second frame yields its own data_valid.
REQ-026 SHALL cover: RST = 1 for one cycle at DATA with bit_cnt = 4 -> IDLE next cycle, all counters 0, no pulse; prescale = 20 then behaves as P=8.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: sequences start/data/parity/stop sampling
// and reports a one-cycle data_valid or framing_err per completed frame.
module uart_rx_fsm (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       framing_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] PARITY  = 3'd3;
    localparam logic [2:0] STOP    = 3'd4;
    localparam logic [2:0] ERR_CHK = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [4:0] r_edge;
    logic [3:0] r_bits;
    logic [4:0] r_pm1;
    logic       r_par_en;
    logic       r_par_flag;
    logic       r_stp_flag;
    logic [4:0] w_pm1_in;
    logic       w_active;
    logic       w_bit_end;
    logic       w_start;

    // Unsupported ratios fall back to 8x oversampling.
    always_comb begin
        w_pm1_in = 5'd7;
        case (prescale)
            6'd16:   w_pm1_in = 5'd15;
            6'd32:   w_pm1_in = 5'd31;
            default: w_pm1_in = 5'd7;
        endcase
    end

    assign w_active  = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
    assign w_bit_end = w_active && (r_edge == r_pm1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!RX_IN) w_next = START;
            end
            START: begin
                if (w_bit_end) w_next = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                if (w_bit_end && (r_bits == 4'd7))
                    w_next = r_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (w_bit_end) w_next = STOP;
            end
            STOP: begin
                if (w_bit_end) w_next = ERR_CHK;
            end
            ERR_CHK: begin
                w_next = RX_IN ? IDLE : START;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_start = (w_next == START) &&
                     ((r_state == IDLE) || (r_state == ERR_CHK));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_edge     <= 5'd0;
            r_bits     <= 4'd0;
            r_pm1      <= 5'd7;
            r_par_en   <= 1'b0;
            r_par_flag <= 1'b0;
            r_stp_flag <= 1'b0;
        end else begin
            r_state <= w_next;
            r_edge  <= (w_active && !w_bit_end) ? r_edge + 5'd1 : 5'd0;

            case (r_state)
                DATA:    if (w_bit_end) r_bits <= r_bits + 4'd1;
                PARITY:  r_bits <= r_bits;
                STOP:    if (w_bit_end) r_bits <= 4'd0;
                default: r_bits <= 4'd0;
            endcase

            // Frame parameters are frozen for the whole frame.
            if (w_start) begin
                r_pm1      <= w_pm1_in;
                r_par_en   <= PAR_EN;
                r_par_flag <= 1'b0;
                r_stp_flag <= 1'b0;
            end else if ((r_state == PARITY) && w_bit_end) begin
                r_par_flag <= par_err;
            end else if ((r_state == STOP) && w_bit_end) begin
                r_stp_flag <= stp_err;
            end
        end
    end

    assign edge_cnt    = r_edge;
    assign bit_cnt     = r_bits;
    assign dat_samp_en = w_active;
    assign strt_chk_en = (r_state == START);
    assign deser_en    = (r_state == DATA);
    assign par_chk_en  = (r_state == PARITY);
    assign stp_chk_en  = (r_state == STOP);
    assign data_valid  = (r_state == ERR_CHK) && !(r_par_flag || r_stp_flag);
    assign framing_err = (r_state == ERR_CHK) && (r_par_flag || r_stp_flag);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: frame-offset reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       framing_err;

    uart_rx_fsm dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
        .prescale(prescale), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en),
        .deser_en(deser_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .framing_err(framing_err)
    );

    always #5 CLK = ~CLK;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_print = 0;
    int cyc     = 0;

    // Model: in a frame, k counts cycles since START was entered.
    bit m_act = 1'b0;
    int m_k   = 0;
    int m_p   = 8;
    bit m_par = 1'b0;
    bit m_pe  = 1'b0;
    bit m_se  = 1'b0;

    int e_ec, e_bc;
    bit e_samp, e_strt, e_deser, e_parc, e_stpc, e_dv, e_fe;

    int o_ec, o_bc;
    bit o_samp, o_strt, o_deser, o_parc, o_stpc, o_dv, o_fe;

    function automatic void model_expect();
        int nb, ph;
        e_ec = 0; e_bc = 0;
        e_samp = 0; e_strt = 0; e_deser = 0;
        e_parc = 0; e_stpc = 0; e_dv = 0; e_fe = 0;
        if (m_act) begin
            nb = 10 + int'(m_par);
            if (m_k == nb * m_p) begin
                e_dv = !(m_pe || m_se);
                e_fe = m_pe || m_se;
            end else begin
                ph     = m_k / m_p;
                e_ec   = m_k % m_p;
                e_samp = 1;
                if (ph == 0) begin
                    e_strt = 1;
                end else if (ph <= 8) begin
                    e_deser = 1;
                    e_bc    = ph - 1;
                end else if (m_par && ph == 9) begin
                    e_parc = 1;
                    e_bc   = 8;
                end else begin
                    e_stpc = 1;
                    e_bc   = 8;
                end
            end
        end
    endfunction

    function automatic void model_start(input logic par, input logic [5:0] ps);
        m_act = 1;
        m_k   = 0;
        m_p   = (ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
        m_par = par;
        m_pe  = 0;
        m_se  = 0;
    endfunction

    function automatic void model_next(input logic rx, par,
                                       input logic [5:0] ps,
                                       input logic gl, pe, se, rst);
        int nb, ph, ec;
        if (rst) begin
            m_act = 0;
        end else if (!m_act) begin
            if (!rx) model_start(par, ps);
        end else begin
            nb = 10 + int'(m_par);
            ph = m_k / m_p;
            ec = m_k % m_p;
            if (m_k == nb * m_p) begin
                if (!rx) model_start(par, ps);
                else m_act = 0;
            end else if (ph == 0 && ec == m_p - 1 && gl) begin
                m_act = 0;
            end else begin
                if (ec == m_p - 1) begin
                    if (m_par && ph == 9) m_pe = pe;
                    if (ph == nb - 1) m_se = se;
                end
                m_k++;
            end
        end
    endfunction

    task automatic compare_cycle();
        logic [15:0] got, want;
        model_expect();
        o_ec = int'(edge_cnt); o_bc = int'(bit_cnt);
        o_samp = dat_samp_en; o_strt = strt_chk_en; o_deser = deser_en;
        o_parc = par_chk_en; o_stpc = stp_chk_en;
        o_dv = data_valid; o_fe = framing_err;
        got  = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en,
                par_chk_en, stp_chk_en, data_valid, framing_err};
        want = {e_ec[4:0], e_bc[3:0], e_samp, e_strt, e_deser,
                e_parc, e_stpc, e_dv, e_fe};
        n_chk++;
        if (got !== want) begin
            n_fail++;
            if (n_print < 30) begin
                n_print++;
                $display("FAIL model cycle %0d: got %h want %h", cyc, got, want);
            end
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic rx, par, input logic [5:0] ps,
                        input logic gl, pe, se, rst);
        @(negedge CLK);
        compare_cycle();
        RX_IN = rx; PAR_EN = par; prescale = ps;
        strt_glitch = gl; par_err = pe; stp_err = se; RST = rst;
        model_next(rx, par, ps, gl, pe, se, rst);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 6'd8, 0, 0, 0, 0);
    endtask

    initial begin
        int c_dv, c_fe, c_ds, c_pc;
        logic rx, par, gl, pe, se, rst;
        logic [5:0] ps;
        RST = 1; RX_IN = 1; PAR_EN = 0; prescale = 6'd8;
        strt_glitch = 0; par_err = 0; stp_err = 0;
        @(posedge CLK);
        step(1, 0, 6'd8, 0, 0, 0, 1);
        lit("reset samp_en", int'(o_samp), 0);
        lit("reset edge_cnt", o_ec, 0);
        lit("reset bit_cnt", o_bc, 0);
        idle(3);

        // P=8, no parity, clean frame
        c_dv = 0;
        for (int i = 0; i < 86; i++) begin
            step(i == 0 ? 1'b0 : 1'b1, 0, 6'd8, 0, 0, 0, 0);
            c_dv += int'(o_dv);
            if (i == 1) lit("A start@1", int'(o_strt), 1);
            if (i == 72) lit("A bitcnt@72", o_bc, 7);
            if (i == 73) lit("A bitcnt@73", o_bc, 8);
            if (i == 73) lit("A stop@73", int'(o_stpc), 1);
            if (i == 81) lit("A dv@81", int'(o_dv), 1);
            if (i == 81) lit("A model dv@81", int'(e_dv), 1);
        end
        lit("A dv count", c_dv, 1);

        // P=8, parity frame; PAR_EN only high on the start edge
        c_dv = 0; c_fe = 0; c_pc = 0;
        for (int i = 0; i < 95; i++) begin
            step(i == 0 ? 1'b0 : 1'b1, i == 0, 6'd8, 0, 0, 0, 0);
            c_dv += int'(o_dv); c_fe += int'(o_fe); c_pc += int'(o_parc);
            if (i == 89) lit("B dv@89", int'(o_dv), 1);
        end
        lit("B parity cycles", c_pc, 8);
        lit("B fe count", c_fe, 0);
        lit("B dv count", c_dv, 1);

        // start glitch aborts the frame
        c_dv = 0; c_fe = 0; c_ds = 0;
        for (int i = 0; i < 20; i++) begin
            step(i == 0 ? 1'b0 : 1'b1, 0, 6'd8, 1, 0, 0, 0);
            c_dv += int'(o_dv); c_fe += int'(o_fe); c_ds += int'(o_deser);
            if (i == 8) lit("C start@8", int'(o_strt), 1);
            if (i == 9) lit("C idle@9", int'(o_samp), 0);
        end
        lit("C deser count", c_ds, 0);
        lit("C pulse count", c_dv + c_fe, 0);

        // P=16 with stop error
        c_dv = 0; c_fe = 0;
        for (int i = 0; i < 170; i++) begin
            step(i == 0 ? 1'b0 : 1'b1, 0, 6'd16, 0, 1, 1, 0);
            c_dv += int'(o_dv); c_fe += int'(o_fe);
            if (i == 161) lit("D fe@161", int'(o_fe), 1);
            if (i == 162) lit("D fe@162", int'(o_fe), 0);
        end
        lit("D fe count", c_fe, 1);
        lit("D dv count", c_dv, 0);

        // back-to-back frames via ERR_CHK
        c_dv = 0;
        for (int i = 0; i < 170; i++) begin
            step((i == 0 || i == 81) ? 1'b0 : 1'b1, 0, 6'd8, 0, 0, 0, 0);
            c_dv += int'(o_dv);
            if (i == 82) lit("E start@82", int'(o_strt), 1);
            if (i == 82) lit("E edge@82", o_ec, 0);
            if (i == 162) lit("E dv@162", int'(o_dv), 1);
        end
        lit("E dv count", c_dv, 2);

        // reset mid-DATA, then prescale 20 behaves as 8
        c_dv = 0; c_fe = 0;
        for (int i = 0; i < 100; i++) begin
            step(i == 0 ? 1'b0 : 1'b1, 0, 6'd8, 0, 0, 0, i == 44);
            c_dv += int'(o_dv); c_fe += int'(o_fe);
            if (i == 44) lit("F bitcnt@44", o_bc, 4);
            if (i == 45) lit("F samp@45", int'(o_samp), 0);
            if (i == 45) lit("F bitcnt@45", o_bc, 0);
        end
        lit("F pulse count", c_dv + c_fe, 0);
        c_dv = 0;
        for (int i = 0; i < 90; i++) begin
            step(i == 0 ? 1'b0 : 1'b1, 0, 6'd20, 0, 0, 0, 0);
            c_dv += int'(o_dv);
            if (i == 8) lit("F edge@8", o_ec, 7);
            if (i == 81) lit("F dv@81", int'(o_dv), 1);
        end
        lit("F dv count", c_dv, 1);

        // randomized traffic
        for (int i = 0; i < 15000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            rx  = m_act ? 1'($urandom_range(0, 1))
                        : ($urandom_range(0, 3) != 0);
            par = 1'($urandom_range(0, 1));
            gl  = ($urandom_range(0, 7) == 0);
            pe  = 1'($urandom_range(0, 1));
            se  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       ps = 6'd8;
                1:       ps = 6'd16;
                2:       ps = 6'd32;
                default: ps = 6'($urandom_range(0, 63));
            endcase
            step(rx, par, ps, gl, pe, se, rst);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
